pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central hazard and stall controller for the 6-stage MIPS pipeline (IF, ID, RR, EX, MEM, WB). It sequences the five inter-stage pipeline registers and the PC. It does this by driving a per-register enable (hold) and flush (bubble insert), and it resolves three conditions:
- load-use RAW hazards,
- jump redirects from EX,
- multi-cycle data-memory waits.

A memory wait that runs too long is caught by a timeout that halts the core.

## Interface
Parameters:
- MEM_WAIT_MAX, 15, max consecutive MEM_WAIT cycles before timeout (1..(2^CNT_W)-1)
- CNT_W, 4, width of wait counter

Ports:
- clk  in  1  single clock, all state on posedge
- rst  in  1  synchronous, active-low reset
- rs_id  in  5  source reg rs of instruction in ID
- rt_id  in  5  source reg rt of instruction in ID
- uses_rt_id  in  1  ID instruction reads rt
- rd_rr  in  5  destination reg of instruction in RR
- regwrite_rr  in  1  RegWrite of instruction in RR
- memtoreg_rr  in  1  MemtoReg (load) of instruction in RR
- rd_ex  in  5  destination reg of instruction in EX
- regwrite_ex  in  1  RegWrite of instruction in EX
- memtoreg_ex  in  1  MemtoReg (load) of instruction in EX
- jump_ex  in  1  jump/branch taken, resolved in EX
- mem_req  in  1  instruction in MEM accesses data memory
- mem_ready  in  1  data memory completes access this cycle
- en_pc  out  1  PC register enable
- en_ifid  out  1  IF/ID register enable
- en_idrr  out  1  ID/RR register enable
- en_rrex  out  1  RR/EX register enable
- en_exmem  out  1  EX/MEM register enable
- en_memwb  out  1  MEM/WB register enable
- flush_ifid  out  1  load bubble (all-zero control) into IF/ID
- flush_idrr  out  1  load bubble into ID/RR
- flush_rrex  out  1  load bubble into RR/EX
- flush_memwb  out  1  load bubble into MEM/WB
- stall_cnt  out  16  saturating count of cycles with en_pc=0
- mem_timeout  out  1  sticky, set on wait timeout

## Operation
- State: RUN, MEM_WAIT, HALT. wait_cnt is a CNT_W-bit register.
- lu_hit term (load-use hit), for stage s in {rr, ex}: memtoreg_s & regwrite_s & (rd_s != 0) & ((rd_s == rs_id) | (uses_rt_id & (rd_s == rt_id))).
- Priority in RUN: mem stall > jump > load-use.
- RUN, mem_req & ~mem_ready (memory stall):
  - all en_* = 1 except en_pc..en_exmem = 0;
  - flush_memwb = 1, so no duplicate WB write;
  - next state MEM_WAIT; wait_cnt <= 1.
- RUN, jump_ex:
  - all en_* = 1;
  - flush_ifid = flush_idrr = flush_rrex = 1;
  - next RUN;
  - any lu_hit is ignored, because the dependent instruction is flushed.
- RUN, lu_hit in either stage:
  - en_pc = en_ifid = 0, others 1;
  - flush_idrr = 1;
  - next RUN;
  - re-evaluated each cycle, so a distance-1 load stalls 2 cycles and a distance-2 load stalls 1 cycle.
- RUN, otherwise: all en_* = 1, all flush_* = 0.
- MEM_WAIT: outputs as for a memory stall.
  - On mem_ready: same cycle all en_* = 1 and no flush; next RUN; wait_cnt <= 0.
  - Else if wait_cnt == MEM_WAIT_MAX: next HALT; mem_timeout <= 1.
  - Else: wait_cnt <= wait_cnt + 1.
  - jump_ex and lu_hit are ignored; EX is frozen, so they persist and are handled in RUN.
- HALT: all en_* = 0, all flush_* = 0. The state is left only by reset.
- stall_cnt increments when en_pc = 0 and rst = 1, and saturates at 16'hFFFF.

## Timing
- en_* and flush_* are combinational from the current state and inputs, and are valid in the same cycle; pipeline registers sample them at the next posedge.
- State, wait_cnt, stall_cnt and mem_timeout are registered, with 1-cycle latency.
- Reset, rst = 0 at posedge: state = RUN, wait_cnt = 0, stall_cnt = 0, mem_timeout = 0. While rst = 0, all en_* = 1 and all flush_* = 1, so every register clears to a bubble.
- Reset mid-MEM_WAIT or in HALT returns to RUN on the next posedge and clears the counters.
- mem_ready arriving in the same cycle as the timeout compare: mem_ready wins, go to RUN.
- A zero-wait access (mem_req & mem_ready in RUN) causes no stall.
- Register $0 never creates a hazard.

## Structure
- Package pipe_ctrl_pkg holds:
  - state enum, RUN = 2'b00, MEM_WAIT = 2'b01, HALT = 2'b10;
  - STALL_CNT_W = 16;
  - REG_ZERO = 5'd0.
- Sub-module hazard_detect: a combinational lu_hit comparator, instantiated twice (RR and EX).

## Test plan
- Load in RR with rd = 5, ID rs = 5 -> 2 cycles of en_pc = en_ifid = 0 and flush_idrr = 1, then release; stall_cnt = 2.
- Load in RR with rd = 5, ID rt = 5, uses_rt_id = 0 -> no stall. Load with rd = 0 matching rs = 0 -> no stall.
- jump_ex together with a lu_hit -> flush_ifid/idrr/rrex = 1, all en = 1, no stall.
- mem_req with mem_ready low for 3 cycles -> 3 cycles frozen with flush_memwb = 1, release on cycle 4; stall_cnt = 3.
- mem_ready never asserted, MEM_WAIT_MAX = 15 -> mem_timeout = 1 and HALT after 16 frozen cycles; rst low for 1 cycle -> RUN, counters 0.
- stall_cnt preloaded near 16'hFFFF by a long HALT -> holds at 16'hFFFF.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALT     = 2'b10
  } state_t;

  localparam int         STALL_CNT_W = 16;
  localparam logic [4:0] REG_ZERO    = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use RAW comparator for one producer stage against the ID consumer.
// Purely combinational; no flow control of its own.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  input  logic       uses_rt_id,
  input  logic [4:0] rd,
  input  logic       regwrite,
  input  logic       memtoreg,
  output logic       lu_hit
);

  assign lu_hit = memtoreg && regwrite && (rd != REG_ZERO) &&
                  ((rd == rs_id) || (uses_rt_id && (rd == rt_id)));

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard/stall controller: enables and flushes are combinational (same cycle),
// state and counters are registered; a memory wait freezes PC..EX/MEM, timeout halts.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             rs_id,
  input  logic [4:0]             rt_id,
  input  logic                   uses_rt_id,
  input  logic [4:0]             rd_rr,
  input  logic                   regwrite_rr,
  input  logic                   memtoreg_rr,
  input  logic [4:0]             rd_ex,
  input  logic                   regwrite_ex,
  input  logic                   memtoreg_ex,
  input  logic                   jump_ex,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  output logic                   en_pc,
  output logic                   en_ifid,
  output logic                   en_idrr,
  output logic                   en_rrex,
  output logic                   en_exmem,
  output logic                   en_memwb,
  output logic                   flush_ifid,
  output logic                   flush_idrr,
  output logic                   flush_rrex,
  output logic                   flush_memwb,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic                   mem_timeout
);

  // Enable vector order: pc, ifid, idrr, rrex, exmem, memwb.
  localparam logic [5:0] EN_ALL = 6'b111111;
  localparam logic [5:0] EN_MEM = 6'b000001;
  localparam logic [5:0] EN_LU  = 6'b001111;
  // Flush vector order: ifid, idrr, rrex, memwb.
  localparam logic [3:0] FL_JMP = 4'b1110;
  localparam logic [3:0] FL_LU  = 4'b0100;
  localparam logic [3:0] FL_MEM = 4'b0001;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             hit_rr, hit_ex, mem_stall;
  logic [5:0]       en_v;
  logic [3:0]       fl_v;

  hazard_detect u_hd_rr (
    .rs_id(rs_id), .rt_id(rt_id), .uses_rt_id(uses_rt_id),
    .rd(rd_rr), .regwrite(regwrite_rr), .memtoreg(memtoreg_rr), .lu_hit(hit_rr)
  );

  hazard_detect u_hd_ex (
    .rs_id(rs_id), .rt_id(rt_id), .uses_rt_id(uses_rt_id),
    .rd(rd_ex), .regwrite(regwrite_ex), .memtoreg(memtoreg_ex), .lu_hit(hit_ex)
  );

  assign mem_stall = mem_req && !mem_ready;

  always_comb begin
    en_v = EN_ALL;
    fl_v = 4'b0000;
    if (!rst) begin
      // Every register loads a bubble while reset is held.
      fl_v = 4'b1111;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            en_v = EN_MEM;
            fl_v = FL_MEM;
          end else if (jump_ex) begin
            fl_v = FL_JMP;
          end else if (hit_rr || hit_ex) begin
            en_v = EN_LU;
            fl_v = FL_LU;
          end
        end
        MEM_WAIT: begin
          if (!mem_ready) begin
            en_v = EN_MEM;
            fl_v = FL_MEM;
          end
        end
        default: begin
          en_v = 6'b000000;
        end
      endcase
    end
  end

  assign {en_pc, en_ifid, en_idrr, en_rrex, en_exmem, en_memwb} = en_v;
  assign {flush_ifid, flush_idrr, flush_rrex, flush_memwb}      = fl_v;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      stall_cnt   <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if (!en_v[5] && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      case (state)
        RUN: begin
          if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= CNT_W'(1);
          end
        end
        MEM_WAIT: begin
          // A completion in the compare cycle takes precedence over the timeout.
          if (mem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == CNT_W'(MEM_WAIT_MAX)) begin
            state       <= HALT;
            mem_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state <= HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scenario bench for pipe_ctrl: expected enable/flush vectors are queued when
// stimulus is applied and popped at the following negedge for comparison.
module tb_pipe_ctrl;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic [4:0] rdrr;
    logic [1:0] wmrr;
    logic [4:0] rdex;
    logic [1:0] wmex;
    logic       jmp;
    logic       req;
    logic       rdy;
  } stim_t;

  typedef struct packed {
    logic [5:0] en;
    logic [3:0] fl;
  } exp_t;

  localparam exp_t E_ALL  = 10'b111111_0000;
  localparam exp_t E_JMP  = 10'b111111_1110;
  localparam exp_t E_LU   = 10'b001111_0100;
  localparam exp_t E_MEM  = 10'b000001_0001;
  localparam exp_t E_NONE = 10'b000000_0000;
  localparam exp_t E_RST  = 10'b111111_1111;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_id, rt_id, rd_rr, rd_ex;
  logic        uses_rt_id, regwrite_rr, memtoreg_rr, regwrite_ex, memtoreg_ex;
  logic        jump_ex, mem_req, mem_ready;
  logic        en_pc, en_ifid, en_idrr, en_rrex, en_exmem, en_memwb;
  logic        flush_ifid, flush_idrr, flush_rrex, flush_memwb;
  logic [15:0] stall_cnt;
  logic        mem_timeout;

  exp_t        got;
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          exp_stall = 0;

  pipe_ctrl #(.MEM_WAIT_MAX(15), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .rs_id(rs_id), .rt_id(rt_id), .uses_rt_id(uses_rt_id),
    .rd_rr(rd_rr), .regwrite_rr(regwrite_rr), .memtoreg_rr(memtoreg_rr),
    .rd_ex(rd_ex), .regwrite_ex(regwrite_ex), .memtoreg_ex(memtoreg_ex),
    .jump_ex(jump_ex), .mem_req(mem_req), .mem_ready(mem_ready),
    .en_pc(en_pc), .en_ifid(en_ifid), .en_idrr(en_idrr), .en_rrex(en_rrex),
    .en_exmem(en_exmem), .en_memwb(en_memwb),
    .flush_ifid(flush_ifid), .flush_idrr(flush_idrr), .flush_rrex(flush_rrex),
    .flush_memwb(flush_memwb), .stall_cnt(stall_cnt), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  assign got = {en_pc, en_ifid, en_idrr, en_rrex, en_exmem, en_memwb,
                flush_ifid, flush_idrr, flush_rrex, flush_memwb};

  function automatic stim_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                               input logic [4:0] rdrr, input logic [1:0] wmrr,
                               input logic [4:0] rdex, input logic [1:0] wmex,
                               input logic jmp, input logic req, input logic rdy);
    mk = {rs, rt, urt, rdrr, wmrr, rdex, wmex, jmp, req, rdy};
  endfunction

  function automatic stim_t idle();
    idle = mk(5'd0, 5'd0, 1'b0, 5'd0, 2'b00, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
  endfunction

  // Apply one cycle of stimulus after the edge, queue its expectation, move to negedge.
  task automatic drive(input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    rs_id = s.rs;  rt_id = s.rt;  uses_rt_id = s.urt;
    rd_rr = s.rdrr; {regwrite_rr, memtoreg_rr} = s.wmrr;
    rd_ex = s.rdex; {regwrite_ex, memtoreg_ex} = s.wmex;
    jump_ex = s.jmp; mem_req = s.req; mem_ready = s.rdy;
    exp_q.push_back(e);
    if (!e.en[5]) exp_stall++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b0;
    {rs_id, rt_id, rd_rr, rd_ex} = '0;
    {uses_rt_id, regwrite_rr, memtoreg_rr, regwrite_ex, memtoreg_ex} = '0;
    {jump_ex, mem_req, mem_ready} = '0;
    exp_q.push_back(E_RST);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL reset_outputs: got %b, expected %b", got, e);
    end
    @(posedge clk);
    #1;
    checks++;
    if (stall_cnt !== 16'd0 || mem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_counters: stall_cnt=%0d timeout=%b, expected 0/0", stall_cnt, mem_timeout);
    end
    rst = 1'b1;
    exp_stall = 0;
  endtask

  task automatic test_load_use();
    stim_t st[5];
    exp_t  ex[5];
    exp_t  e;
    st = '{mk(5'd5, 5'd0, 1'b0, 5'd5, 2'b11, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0),
           mk(5'd5, 5'd0, 1'b0, 5'd0, 2'b00, 5'd5, 2'b11, 1'b0, 1'b0, 1'b0),
           idle(),
           mk(5'd9, 5'd0, 1'b0, 5'd0, 2'b00, 5'd9, 2'b11, 1'b0, 1'b0, 1'b0),
           idle()};
    ex = '{E_LU, E_LU, E_ALL, E_LU, E_ALL};
    for (int i = 0; i < 5; i++) begin
      drive(st[i], ex[i]);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL load_use[%0d]: got en=%b fl=%b, expected en=%b fl=%b", i, got.en, got.fl, e.en, e.fl);
      end
      if (i == 2) begin
        @(posedge clk);
        #1;
        checks++;
        if (stall_cnt !== 16'd2) begin
          errors++;
          $display("FAIL load_use_stall_cnt: got %0d, expected 2", stall_cnt);
        end
      end
    end
  endtask

  task automatic test_no_hazard();
    stim_t st[7];
    exp_t  ex[7];
    exp_t  e;
    st = '{mk(5'd1, 5'd5, 1'b0, 5'd5, 2'b11, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0),
           mk(5'd0, 5'd0, 1'b1, 5'd0, 2'b11, 5'd0, 2'b11, 1'b0, 1'b0, 1'b0),
           mk(5'd5, 5'd0, 1'b0, 5'd5, 2'b10, 5'd5, 2'b10, 1'b0, 1'b0, 1'b0),
           mk(5'd5, 5'd0, 1'b0, 5'd5, 2'b01, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0),
           mk(5'd1, 5'd7, 1'b1, 5'd0, 2'b00, 5'd7, 2'b11, 1'b0, 1'b0, 1'b0),
           mk(5'd3, 5'd7, 1'b1, 5'd7, 2'b11, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0),
           idle()};
    ex = '{E_ALL, E_ALL, E_ALL, E_ALL, E_LU, E_LU, E_ALL};
    for (int i = 0; i < 7; i++) begin
      drive(st[i], ex[i]);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL no_hazard[%0d]: got en=%b fl=%b, expected en=%b fl=%b", i, got.en, got.fl, e.en, e.fl);
      end
    end
  endtask

  task automatic test_jump();
    stim_t st[4];
    exp_t  ex[4];
    exp_t  e;
    st = '{mk(5'd5, 5'd0, 1'b0, 5'd5, 2'b11, 5'd5, 2'b11, 1'b1, 1'b0, 1'b0),
           mk(5'd0, 5'd0, 1'b0, 5'd0, 2'b00, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0),
           mk(5'd0, 5'd0, 1'b0, 5'd0, 2'b00, 5'd0, 2'b00, 1'b1, 1'b1, 1'b1),
           idle()};
    ex = '{E_JMP, E_JMP, E_JMP, E_ALL};
    for (int i = 0; i < 4; i++) begin
      drive(st[i], ex[i]);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL jump[%0d]: got en=%b fl=%b, expected en=%b fl=%b", i, got.en, got.fl, e.en, e.fl);
      end
    end
  endtask

  task automatic test_mem_wait();
    stim_t st[10];
    exp_t  ex[10];
    exp_t  e;
    stim_t w, r, wj;
    w  = mk(5'd0, 5'd0, 1'b0, 5'd0, 2'b00, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0);
    r  = mk(5'd0, 5'd0, 1'b0, 5'd0, 2'b00, 5'd0, 2'b00, 1'b0, 1'b1, 1'b1);
    wj = mk(5'd5, 5'd0, 1'b0, 5'd5, 2'b11, 5'd0, 2'b00, 1'b1, 1'b1, 1'b0);
    st = '{w, w, w, r, r, wj, wj,
           mk(5'd5, 5'd0, 1'b0, 5'd5, 2'b11, 5'd0, 2'b00, 1'b1, 1'b1, 1'b1),
           mk(5'd5, 5'd0, 1'b0, 5'd5, 2'b11, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0),
           idle()};
    ex = '{E_MEM, E_MEM, E_MEM, E_ALL, E_ALL, E_MEM, E_MEM, E_ALL, E_JMP, E_ALL};
    for (int i = 0; i < 10; i++) begin
      drive(st[i], ex[i]);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL mem_wait[%0d]: got en=%b fl=%b, expected en=%b fl=%b", i, got.en, got.fl, e.en, e.fl);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (stall_cnt !== 16'(exp_stall)) begin
      errors++;
      $display("FAIL mem_wait_stall_cnt: got %0d, expected %0d", stall_cnt, exp_stall);
    end
  endtask

  task automatic test_timeout_boundary();
    exp_t e;
    for (int i = 0; i < 17; i++) begin
      if (i < 15)       drive(mk(5'd0, 5'd0, 1'b0, 5'd0, 2'b00, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0), E_MEM);
      else if (i == 15) drive(mk(5'd0, 5'd0, 1'b0, 5'd0, 2'b00, 5'd0, 2'b00, 1'b0, 1'b1, 1'b1), E_ALL);
      else              drive(idle(), E_ALL);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL timeout_boundary[%0d]: got en=%b fl=%b, expected en=%b fl=%b", i, got.en, got.fl, e.en, e.fl);
      end
    end
    checks++;
    if (mem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_boundary_flag: got %b, expected 0", mem_timeout);
    end
  endtask

  task automatic enter_halt(input string tag);
    exp_t e;
    for (int i = 0; i < 18; i++) begin
      if (i < 16)       drive(mk(5'd0, 5'd0, 1'b0, 5'd0, 2'b00, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0), E_MEM);
      else              drive(mk(5'd0, 5'd0, 1'b0, 5'd0, 2'b00, 5'd0, 2'b00, 1'b1, 1'b1, 1'b1), E_NONE);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s[%0d]: got en=%b fl=%b, expected en=%b fl=%b", tag, i, got.en, got.fl, e.en, e.fl);
      end
      if (i == 15 || i == 16) begin
        checks++;
        if (mem_timeout !== (i == 16)) begin
          errors++;
          $display("FAIL %s_flag[%0d]: got %b, expected %b", tag, i, mem_timeout, (i == 16));
        end
      end
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    enter_halt("timeout");
    @(posedge clk);
    #1;
    checks++;
    if (stall_cnt !== 16'(exp_stall)) begin
      errors++;
      $display("FAIL timeout_stall_cnt: got %0d, expected %0d", stall_cnt, exp_stall);
    end
    rst = 1'b0;
    exp_q.push_back(E_RST);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL halt_reset_outputs: got %b, expected %b", got, e);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_stall = 0;
    checks++;
    if (stall_cnt !== 16'd0 || mem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset_counters: stall_cnt=%0d timeout=%b, expected 0/0", stall_cnt, mem_timeout);
    end
    drive(idle(), E_ALL);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL halt_reset_run: got %b, expected %b", got, e);
    end
  endtask

  task automatic test_saturation();
    enter_halt("saturate");
    repeat (65560) @(posedge clk);
    #1;
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL stall_saturate: got %h, expected ffff", stall_cnt);
    end
    @(posedge clk);
    #1;
    checks++;
    if (stall_cnt !== 16'hFFFF || got !== E_NONE) begin
      errors++;
      $display("FAIL stall_hold: got cnt=%h out=%b, expected ffff/%b", stall_cnt, got, E_NONE);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_jump();
    test_mem_wait();
    test_timeout_boundary();
    test_timeout();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
